// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the MINI-RISC pipeline sequencer
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        LDSTALL = 3'd1,
        FLUSH   = 3'd2,
        DRAIN   = 3'd3,
        HALTED  = 3'd4
    } pipe_seq_state_t;

    localparam int unsigned STG_F = 0;
    localparam int unsigned STG_D = 1;
    localparam int unsigned STG_E = 2;
    localparam int unsigned STG_M = 3;
    localparam int unsigned STG_W = 4;

    // Instruction word the D/E register captures while bubble_E is high (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Down-counter width able to hold values 0 .. max_cyc-1
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit event counter that sticks at all-ones instead of wrapping
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_seq_ctrl
//  Description : 5-stage pipeline sequencer: stage enables, bubble and flush.
//                Performance counters are built only with PIPE_SEQ_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_seq_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int DRAIN_CYC  = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall_i,
    input  logic             hz_flush_i,
    input  logic             halt_D,
    input  logic             mem_access_M,
    input  logic             dmem_ready,
    output logic             en_F,
    output logic             en_D,
    output logic             en_E,
    output logic             en_M,
    output logic             en_W,
    output logic             bubble_E,
    output logic             flush_D,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int CNT_MAX = (LOAD_LAT > BR_PENALTY)
                           ? ((LOAD_LAT > DRAIN_CYC) ? LOAD_LAT : DRAIN_CYC)
                           : ((BR_PENALTY > DRAIN_CYC) ? BR_PENALTY : DRAIN_CYC);
    localparam int CW = cnt_width(CNT_MAX);

    // The RUN-state cycle that sees the event is the first of the hold, so the
    // follow-on state covers the remaining N-1 cycles (reload N-2).
    localparam logic [CW-1:0] c_ld_reload    = (LOAD_LAT   > 1) ? CW'(LOAD_LAT - 2)   : '0;
    localparam logic [CW-1:0] c_br_reload    = (BR_PENALTY > 1) ? CW'(BR_PENALTY - 2) : '0;
    localparam logic [CW-1:0] c_drain_reload = (DRAIN_CYC  > 1) ? CW'(DRAIN_CYC - 2)  : '0;

    pipe_seq_state_t r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_halted;
    logic            w_freeze;
    logic [STG_W:STG_F] w_en;
    logic            w_bubble;
    logic            w_flush;

    assign w_freeze = mem_access_M && !dmem_ready && (r_state != HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_halted <= (w_state_nxt == HALTED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en        = '0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        if (!w_freeze) begin
            case (r_state)
                RUN: begin
                    if (halt_D) begin
                        w_en[STG_E] = 1'b1;
                        w_en[STG_M] = 1'b1;
                        w_en[STG_W] = 1'b1;
                        w_bubble    = 1'b1;
                        if (DRAIN_CYC > 1) begin
                            w_state_nxt = DRAIN;
                            w_cnt_nxt   = c_drain_reload;
                        end else begin
                            w_state_nxt = HALTED;
                        end
                    end else if (hz_stall_i) begin
                        w_en[STG_E] = 1'b1;
                        w_en[STG_M] = 1'b1;
                        w_en[STG_W] = 1'b1;
                        w_bubble    = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = LDSTALL;
                            w_cnt_nxt   = c_ld_reload;
                        end
                    end else if (hz_flush_i) begin
                        w_en    = '1;
                        w_flush = 1'b1;
                        if (BR_PENALTY > 1) begin
                            w_state_nxt = FLUSH;
                            w_cnt_nxt   = c_br_reload;
                        end
                    end else begin
                        w_en = '1;
                    end
                end
                LDSTALL, DRAIN: begin
                    w_en[STG_E] = 1'b1;
                    w_en[STG_M] = 1'b1;
                    w_en[STG_W] = 1'b1;
                    w_bubble    = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = (r_state == DRAIN) ? HALTED : RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                FLUSH: begin
                    w_en    = '1;
                    w_flush = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                HALTED: begin
                    w_state_nxt = HALTED;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Pipeline registers must not move while reset is asserted
    assign en_F     = w_en[STG_F] & ~rst;
    assign en_D     = w_en[STG_D] & ~rst;
    assign en_E     = w_en[STG_E] & ~rst;
    assign en_M     = w_en[STG_M] & ~rst;
    assign en_W     = w_en[STG_W] & ~rst;
    assign bubble_E = w_bubble    & ~rst;
    assign flush_D  = w_flush     & ~rst;
    assign halted   = r_halted;

`ifdef PIPE_SEQ_PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = !w_freeze &&
                         ((r_state == LDSTALL) ||
                          ((r_state == RUN) && !halt_D && hz_stall_i));
    assign w_flush_inc = !w_freeze &&
                         ((r_state == FLUSH) ||
                          ((r_state == RUN) && !halt_D && !hz_stall_i && hz_flush_i));

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .clr (1'b0),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .clr (1'b0),
        .q   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_freeze),
        .clr (1'b0),
        .q   (wait_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_seq_ctrl
//  Description : Directed table, corner sequences and random run of pipe_seq_ctrl
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_seq_ctrl;

    localparam int LOAD_LAT   = 2;
    localparam int BR_PENALTY = 2;
    localparam int DRAIN_CYC  = 3;
    localparam int CNT_W      = 4;
    localparam int SAT        = (1 << CNT_W) - 1;
`ifdef PIPE_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {en_F, en_D, en_E, en_M, en_W, bubble_E, flush_D}
    localparam logic [6:0] C_OFF   = 7'b00000_0_0;
    localparam logic [6:0] C_RUN   = 7'b11111_0_0;
    localparam logic [6:0] C_STALL = 7'b00111_1_0;
    localparam logic [6:0] C_FLUSH = 7'b11111_0_1;

    logic clk = 1'b0;
    logic rst, hz_stall_i, hz_flush_i, halt_D, mem_access_M, dmem_ready;
    logic en_F, en_D, en_E, en_M, en_W, bubble_E, flush_D, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    always #5 clk = ~clk;

    pipe_seq_ctrl #(
        .LOAD_LAT   (LOAD_LAT),
        .BR_PENALTY (BR_PENALTY),
        .DRAIN_CYC  (DRAIN_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hz_stall_i   (hz_stall_i),
        .hz_flush_i   (hz_flush_i),
        .halt_D       (halt_D),
        .mem_access_M (mem_access_M),
        .dmem_ready   (dmem_ready),
        .en_F         (en_F),
        .en_D         (en_D),
        .en_E         (en_E),
        .en_M         (en_M),
        .en_W         (en_W),
        .bubble_E     (bubble_E),
        .flush_D      (flush_D),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .wait_cnt     (wait_cnt)
    );

    typedef struct packed {
        logic       r;
        logic       s;
        logic       f;
        logic       h;
        logic       m;
        logic       d;
        logic [6:0] ctl;
        logic       hl;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining-cycle budgets for each kind of hold
    bit m_halted;
    int m_stall_rem, m_flush_rem, m_drain_rem;
    int m_stall, m_flush, m_wait;

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        m_halted    = 1'b0;
        m_stall_rem = 0;
        m_flush_rem = 0;
        m_drain_rem = 0;
        m_stall     = 0;
        m_flush     = 0;
        m_wait      = 0;
    endtask

    function automatic logic [6:0] model_ctl(input logic r, s, f, h, m, d);
        if (r || m_halted)                     return C_OFF;
        if (m && !d)                           return C_OFF;
        if (m_stall_rem > 0 || m_drain_rem > 0) return C_STALL;
        if (m_flush_rem > 0)                   return C_FLUSH;
        if (h || s)                            return C_STALL;
        if (f)                                 return C_FLUSH;
        return C_RUN;
    endfunction

    task automatic model_update(input logic s, f, h, m, d);
        if (m_halted) return;
        if (m && !d) begin
            m_wait = sat_inc(m_wait);
        end else if (m_stall_rem > 0) begin
            m_stall_rem--;
            m_stall = sat_inc(m_stall);
        end else if (m_drain_rem > 0) begin
            m_drain_rem--;
            if (m_drain_rem == 0) m_halted = 1'b1;
        end else if (m_flush_rem > 0) begin
            m_flush_rem--;
            m_flush = sat_inc(m_flush);
        end else if (h) begin
            if (DRAIN_CYC == 1) m_halted = 1'b1;
            else                m_drain_rem = DRAIN_CYC - 1;
        end else if (s) begin
            m_stall     = sat_inc(m_stall);
            m_stall_rem = LOAD_LAT - 1;
        end else if (f) begin
            m_flush     = sat_inc(m_flush);
            m_flush_rem = BR_PENALTY - 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; checks at the falling edge, then advances one cycle.
    task automatic apply(input vec_t v, input bit use_tbl);
        logic [6:0] act_ctl;
        rst = v.r; hz_stall_i = v.s; hz_flush_i = v.f;
        halt_D = v.h; mem_access_M = v.m; dmem_ready = v.d;
        if (v.r) model_reset();
        #4;
        act_ctl = {en_F, en_D, en_E, en_M, en_W, bubble_E, flush_D};
        check("ctl", 32'(act_ctl), 32'(model_ctl(v.r, v.s, v.f, v.h, v.m, v.d)));
        check("halted", 32'(halted), 32'(m_halted));
        check("stall_cnt", 32'(stall_cnt), PERF ? m_stall : 0);
        check("flush_cnt", 32'(flush_cnt), PERF ? m_flush : 0);
        check("wait_cnt", 32'(wait_cnt), PERF ? m_wait : 0);
        if (use_tbl) begin
            check("tbl_ctl", 32'(act_ctl), 32'(v.ctl));
            check("tbl_halted", 32'(halted), 32'(v.hl));
        end
        @(posedge clk);
        if (!v.r) model_update(v.s, v.f, v.h, v.m, v.d);
        #1;
    endtask

    function automatic vec_t mk(input logic r, s, f, h, m, d, input logic [6:0] c, input logic hl);
        return {r, s, f, h, m, d, c, hl};
    endfunction

    vec_t tbl [24];
    vec_t idle, rstv, stl;

    initial begin
        rst = 1'b1; hz_stall_i = 1'b0; hz_flush_i = 1'b0;
        halt_D = 1'b0; mem_access_M = 1'b0; dmem_ready = 1'b1;
        model_reset();
        @(posedge clk); #1;

        //            r  s  f  h  m  d   ctl      halted
        tbl[0]  = mk(1, 1, 1, 1, 1, 0, C_OFF,   0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, C_OFF,   0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, C_RUN,   0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 1, C_STALL, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, C_STALL, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, C_RUN,   0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 1, C_STALL, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 1, C_STALL, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 1, C_FLUSH, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, C_FLUSH, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, C_RUN,   0);
        tbl[11] = mk(0, 1, 0, 0, 0, 1, C_STALL, 0);
        tbl[12] = mk(0, 0, 0, 0, 1, 0, C_OFF,   0);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, C_OFF,   0);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, C_OFF,   0);
        tbl[15] = mk(0, 0, 0, 0, 1, 1, C_STALL, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, C_RUN,   0);
        tbl[17] = mk(0, 0, 0, 1, 0, 1, C_STALL, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, C_STALL, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 1, C_STALL, 0);
        tbl[20] = mk(0, 1, 1, 0, 1, 0, C_OFF,   1);
        tbl[21] = mk(0, 0, 0, 1, 0, 1, C_OFF,   1);
        tbl[22] = mk(1, 0, 0, 0, 0, 1, C_OFF,   0);
        tbl[23] = mk(0, 0, 0, 0, 0, 1, C_RUN,   0);

        for (int i = 0; i < 24; i++) apply(tbl[i], 1'b1);

        idle = mk(0, 0, 0, 0, 0, 1, C_OFF, 0);
        rstv = mk(1, 0, 0, 0, 0, 1, C_OFF, 0);
        stl  = mk(0, 1, 0, 0, 0, 1, C_OFF, 0);

        // Single stall pulse holds F/D for LOAD_LAT cycles
        apply(rstv, 1'b0);
        apply(stl, 1'b0);
        apply(idle, 1'b0);
        check("pulse_stall_cnt", 32'(stall_cnt), PERF ? 2 : 0);
        apply(idle, 1'b0);

        // Freeze during the stall tail: wait counts, stall count unchanged by it
        apply(rstv, 1'b0);
        apply(stl, 1'b0);
        for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 0, 1, 0, C_OFF, 0), 1'b0);
        check("frz_stall_cnt", 32'(stall_cnt), PERF ? 1 : 0);
        apply(mk(0, 0, 0, 0, 1, 1, C_OFF, 0), 1'b0);
        check("frz_wait_cnt", 32'(wait_cnt), PERF ? 3 : 0);
        check("frz_stall_done", 32'(stall_cnt), PERF ? 2 : 0);
        apply(idle, 1'b0);

        // Saturation: 20 consecutive stall cycles
        apply(rstv, 1'b0);
        for (int i = 0; i < 20; i++) apply(stl, 1'b0);
        check("sat_stall_cnt", 32'(stall_cnt), PERF ? SAT : 0);

        // Randomized traffic against the reference model
        apply(rstv, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v.r   = ($urandom_range(0, 99) == 0);
            v.s   = ($urandom_range(0, 4) == 0);
            v.f   = ($urandom_range(0, 4) == 0);
            v.h   = ($urandom_range(0, 49) == 0);
            v.m   = ($urandom_range(0, 9) < 4);
            v.d   = $urandom_range(0, 1) == 1;
            v.ctl = C_OFF;
            v.hl  = 1'b0;
            apply(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
